wb_arbiter: RTL



---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_arbiter_if.sv | 46 ++++
 rtl/wb_fifo2w1r.sv | 94 +++++++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Writeback shared definitions: result width constants, queue entry type
// and the reset level shared with the register file.

`ifndef RST_ENABLED
`define RST_ENABLED 1'b1
`endif

package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU/MDU result handshakes in, register-file write port,
// pending-write mask and occupancy out. master = producers, slave = arbiter.

interface wb_arbiter_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;

    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_waddr;
    logic [DATA_W-1:0] mdu_wdata;

    logic              rf_wena;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [31:0]       pend_mask;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output mdu_valid, mdu_waddr, mdu_wdata,
        input  alu_ready, mdu_ready,
        input  rf_wena, rf_waddr, rf_wdata,
        input  pend_mask, count, empty
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        output alu_ready, mdu_ready,
        output rf_wena, rf_waddr, rf_wdata,
        output pend_mask, count, empty
    );

endinterface

// File: rtl/wb_fifo2w1r.sv
// Dual-write single-read circular buffer for writeback results.
// Ports: clk/rst; push0/entry0 (older), push1/entry1 (younger, only taken
// together with push0); pop; head, all entries, occupancy vector, count, empty.

module wb_fifo2w1r
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push0_i,
    input  entry_t                       entry0_i,
    input  logic                         push1_i,
    input  entry_t                       entry1_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output entry_t                       entries_o [DEPTH],
    output logic [DEPTH-1:0]             occ_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PTR_W-1:0]   wr_ptr_p1;
    logic               dual;
    logic               pop_eff;

    assign wr_ptr_p1 = wr_ptr_q + 1'b1;
    assign dual      = push0_i && push1_i;
    assign pop_eff   = pop_i && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push0_i) begin
            mem_d[wr_ptr_q] = entry0_i;
            wr_ptr_d        = wr_ptr_p1;
        end
        if (dual) begin
            mem_d[wr_ptr_p1] = entry1_i;
            wr_ptr_d         = wr_ptr_p1 + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q
                + CNT_W'(push0_i)
                + CNT_W'(dual)
                - CNT_W'(pop_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RST_ENABLED) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot g is live when its distance past the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_occ
        logic [PTR_W-1:0] off;
        assign off      = PTR_W'(g) - rd_ptr_q;
        assign occ_o[g] = {1'b0, off} < count_q;
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and MDU results into an in-order queue and
// retires one register-file write per cycle.
// Ports: clk, rst (async, active-high), bus (wb_arbiter_if.slave): ALU/MDU
// valid/ready/waddr/wdata in, rf_wena/rf_waddr/rf_wdata, pend_mask, count,
// empty out.

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    logic [CNT_W-1:0]  count;
    logic              empty;
    entry_t            head;
    entry_t            entries [DEPTH];
    logic [DEPTH-1:0]  occ;

    logic              alu_rdy;
    logic              mdu_rdy;
    logic              alu_push;
    logic              mdu_push;
    logic              push0;
    logic              push1;
    entry_t            entry0;
    entry_t            entry1;
    entry_t            alu_ent;
    entry_t            mdu_ent;
    logic [31:0]       pend;

    // Ready looks only at the registered count and keeps two free slots
    // for the ALU so a same-cycle dual push always fits.
    assign mdu_rdy = count <= CNT_W'(DEPTH - 1);
    assign alu_rdy = count <= CNT_W'(DEPTH - 2);

    // Writes to r0 are handshaken but dropped.
    assign mdu_push = bus.mdu_valid && mdu_rdy && (bus.mdu_waddr != '0);
    assign alu_push = bus.alu_valid && alu_rdy && (bus.alu_waddr != '0);

    assign mdu_ent = '{waddr: bus.mdu_waddr, wdata: bus.mdu_wdata};
    assign alu_ent = '{waddr: bus.alu_waddr, wdata: bus.alu_wdata};

    // MDU is the older instruction, so it takes the first slot.
    always_comb begin
        push0  = mdu_push || alu_push;
        push1  = mdu_push && alu_push;
        entry0 = mdu_push ? mdu_ent : alu_ent;
        entry1 = alu_ent;
    end

    wb_fifo2w1r #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0_i   (push0),
        .entry0_i  (entry0),
        .push1_i   (push1),
        .entry1_i  (entry1),
        .pop_i     (!empty),
        .head_o    (head),
        .entries_o (entries),
        .occ_o     (occ),
        .count_o   (count),
        .empty_o   (empty)
    );

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i]) begin
                pend[entries[i].waddr] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    // Stale slots keep old data, so the write port is masked when empty.
    assign bus.rf_wena   = !empty;
    assign bus.rf_waddr  = empty ? '0 : head.waddr;
    assign bus.rf_wdata  = empty ? '0 : head.wdata;
    assign bus.alu_ready = alu_rdy;
    assign bus.mdu_ready = mdu_rdy;
    assign bus.pend_mask = pend;
    assign bus.count     = count;
    assign bus.empty     = empty;

endmodule
